xaddrgen_nd: RTL and testbench

//  N-level nested-loop address generator for Versat memory units; successor to the two-level generator.

---
 rtl/xaddrgen_nd.sv | 172 +++++++++++++++++
 tb/tb_xaddrgen_nd.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/xaddrgen_nd.sv
// N-level nested-loop address generator for Versat memory units.
// Level 0 is a period/duty/delay enable pattern; outer levels add shifts.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   run_i             start pulse, latches all config
//   pause_i           freezes counters, address and state
//   start_i           initial address
//   period_i          level-0 period (0 acts as 1)
//   duty_i            enabled cycles per period (clamped to period)
//   delay_i           idle cycles between run and first period
//   incr_i            signed per-access increment
//   iter_i, shift_i   per-level iterations and signed shifts, W bits each
//   addr_o            address, valid with mem_en_o
//   mem_en_o          memory access enable
//   done_o            generator idle
module xaddrgen_nd #(
  parameter int MEM_ADDR_W = 10,
  parameter int PERIOD_W   = 10,
  parameter int NLOOPS     = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         run_i,
  input  logic                         pause_i,
  input  logic [MEM_ADDR_W-1:0]        start_i,
  input  logic [PERIOD_W-1:0]          period_i,
  input  logic [PERIOD_W-1:0]          duty_i,
  input  logic [PERIOD_W-1:0]          delay_i,
  input  logic [MEM_ADDR_W-1:0]        incr_i,
  input  logic [NLOOPS*MEM_ADDR_W-1:0] iter_i,
  input  logic [NLOOPS*MEM_ADDR_W-1:0] shift_i,
  output logic [MEM_ADDR_W-1:0]        addr_o,
  output logic                         mem_en_o,
  output logic                         done_o
);

  localparam int W = MEM_ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_RUN
  } state_t;

  state_t r_state, w_state_nx;

  logic [W-1:0]        r_addr, w_addr_nx, w_sum;
  logic [W-1:0]        r_incr;
  logic [NLOOPS*W-1:0] r_shift;
  logic [W-1:0]        r_iter [NLOOPS];
  logic [W-1:0]        r_cnt  [NLOOPS];
  logic [W-1:0]        w_cnt_nx [NLOOPS];
  logic [W-1:0]        w_iter_eff [NLOOPS];
  logic [PERIOD_W-1:0] r_period, r_duty, r_p, r_dly;
  logic [PERIOD_W-1:0] w_p_nx, w_dly_nx;
  logic [PERIOD_W-1:0] w_period_eff, w_duty_eff;
  logic [NLOOPS-1:0]   w_wrap, w_step;
  logic                w_en, w_last;

  // Config sanitising applied at the moment run_i latches it.
  always_comb begin
    w_period_eff = (period_i == '0) ? PERIOD_W'(1) : period_i;
    w_duty_eff   = (duty_i > w_period_eff) ? w_period_eff : duty_i;
    for (int k = 0; k < NLOOPS; k++) begin
      w_iter_eff[k] = iter_i[k*W +: W];
      if (k > 0 && w_iter_eff[k] == '0)
        w_iter_eff[k] = W'(1);
    end
  end

  // Loop bookkeeping: a level steps when the one below wraps.
  always_comb begin
    w_en      = (r_state == S_RUN) && !pause_i && (r_p < r_duty);
    w_last    = (r_p == r_period - PERIOD_W'(1));
    w_step[0] = w_last;
    w_wrap[0] = w_last && (r_cnt[0] == r_iter[0] - W'(1));
    for (int k = 1; k < NLOOPS; k++) begin
      w_step[k] = w_wrap[k-1];
      w_wrap[k] = w_wrap[k-1] && (r_cnt[k] == r_iter[k] - W'(1));
    end
    // All increments and shifts of one cycle fold into one sum.
    w_sum = r_addr;
    if (w_en)
      w_sum = w_sum + r_incr;
    if (w_last)
      w_sum = w_sum + r_shift[0 +: W];
    for (int k = 0; k < NLOOPS-1; k++)
      if (w_wrap[k])
        w_sum = w_sum + r_shift[(k+1)*W +: W];
  end

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_p_nx     = r_p;
    w_dly_nx   = r_dly;
    w_cnt_nx   = r_cnt;
    if (run_i) begin
      w_addr_nx = start_i;
      w_p_nx    = '0;
      w_dly_nx  = delay_i - PERIOD_W'(1);
      for (int k = 0; k < NLOOPS; k++)
        w_cnt_nx[k] = '0;
      if (iter_i[0 +: W] == '0)
        w_state_nx = S_IDLE;
      else if (delay_i == '0)
        w_state_nx = S_RUN;
      else
        w_state_nx = S_DELAY;
    end else if (!pause_i) begin
      unique case (r_state)
        S_DELAY: begin
          if (r_dly == '0)
            w_state_nx = S_RUN;
          else
            w_dly_nx = r_dly - PERIOD_W'(1);
        end
        S_RUN: begin
          w_p_nx = w_last ? '0 : r_p + PERIOD_W'(1);
          for (int k = 0; k < NLOOPS; k++) begin
            if (w_wrap[k])
              w_cnt_nx[k] = '0;
            else if (w_step[k])
              w_cnt_nx[k] = r_cnt[k] + W'(1);
          end
          // Final wrap keeps the last presented address.
          if (w_wrap[NLOOPS-1])
            w_state_nx = S_IDLE;
          else
            w_addr_nx = w_sum;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_incr   <= '0;
      r_shift  <= '0;
      r_period <= '0;
      r_duty   <= '0;
      r_p      <= '0;
      r_dly    <= '0;
      for (int k = 0; k < NLOOPS; k++) begin
        r_iter[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_p     <= w_p_nx;
      r_dly   <= w_dly_nx;
      r_cnt   <= w_cnt_nx;
      if (run_i) begin
        r_incr   <= incr_i;
        r_shift  <= shift_i;
        r_period <= w_period_eff;
        r_duty   <= w_duty_eff;
        r_iter   <= w_iter_eff;
      end
    end
  end

  assign addr_o   = r_addr;
  assign mem_en_o = w_en;
  assign done_o   = (r_state == S_IDLE);

endmodule

// File: tb/tb_xaddrgen_nd.sv
// Scoreboard bench for xaddrgen_nd with two loop levels.
// Directed vectors; a negedge monitor checks every enabled address.
module tb_xaddrgen_nd;
  localparam int W  = 10;
  localparam int PW = 10;
  localparam int NL = 2;

  logic          clk = 0;
  logic          rst_i = 1;
  logic          run_i = 0;
  logic          pause_i = 0;
  logic [W-1:0]  start_i = '0;
  logic [PW-1:0] period_i = '0;
  logic [PW-1:0] duty_i = '0;
  logic [PW-1:0] delay_i = '0;
  logic [W-1:0]  incr_i = '0;
  logic [NL*W-1:0] iter_i = '0;
  logic [NL*W-1:0] shift_i = '0;
  logic [W-1:0]  addr_o;
  logic          mem_en_o;
  logic          done_o;

  int total = 0;
  int bad = 0;
  int n_en = 0;
  int q[$];

  always #5 clk = ~clk;

  xaddrgen_nd #(.MEM_ADDR_W(W), .PERIOD_W(PW), .NLOOPS(NL)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .pause_i(pause_i),
    .start_i(start_i), .period_i(period_i), .duty_i(duty_i),
    .delay_i(delay_i), .incr_i(incr_i), .iter_i(iter_i),
    .shift_i(shift_i), .addr_o(addr_o), .mem_en_o(mem_en_o),
    .done_o(done_o)
  );

  always @(negedge clk) begin
    if (mem_en_o === 1'b1) begin
      int e;
      n_en++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_en addr=%0d required=none", addr_o);
      end else begin
        e = q.pop_front();
        if (addr_o !== W'(e)) begin
          bad++;
          $display("FAIL addr got=%0d required=%0d", addr_o, W'(e));
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask

  task automatic cfg(input int st, input int per, input int dty,
                     input int dly, input int inc, input int it0,
                     input int it1, input int s0, input int s1);
    start_i  = W'(st);
    period_i = PW'(per);
    duty_i   = PW'(dty);
    delay_i  = PW'(dly);
    incr_i   = W'(inc);
    iter_i   = {W'(it1), W'(it0)};
    shift_i  = {W'(s1), W'(s0)};
  endtask

  task automatic push(input int v[]);
    foreach (v[i]) q.push_back(v[i]);
  endtask

  // Leaves time at 1ns into cycle T+1 of the run edge T.
  task automatic start_run();
    @(posedge clk); #1;
    run_i = 1;
    @(posedge clk); #1;
    run_i = 0;
    n_en = 0;
  endtask

  task automatic run_loop(input string nm, input int exp_done,
                          input int exp_first, input int exp_en,
                          input int pa, input int plen);
    int first = 0;
    int dn = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      pause_i = (cyc >= pa && cyc < pa + plen);
      @(negedge clk);
      if (cyc == 1 && exp_done != 1)
        check({nm, "_done_low"}, int'(done_o), 0);
      if (pause_i)
        check({nm, "_pause_en"}, int'(mem_en_o), 0);
      if (mem_en_o && first == 0) first = cyc;
      if (done_o) begin
        dn = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    pause_i = 0;
    check({nm, "_done_cyc"}, dn, exp_done);
    check({nm, "_first_en"}, first, exp_first);
    check({nm, "_n_en"}, n_en, exp_en);
    check({nm, "_q_left"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", int'(addr_o), 0);
    check("rst_en", int'(mem_en_o), 0);
    check("rst_done", int'(done_o), 1);
    rst_i = 0;

    cfg(0, 4, 2, 0, 1, 2, 2, 2, 0);
    push('{0, 1, 4, 5, 8, 9, 12, 13});
    start_run();
    run_loop("basic", 17, 1, 8, 0, 0);

    cfg(0, 1, 1, 0, 3, 2, 3, 0, -5);
    push('{0, 3, 1, 4, 2, 5});
    start_run();
    run_loop("transpose", 7, 1, 6, 0, 0);

    cfg(0, 4, 2, 3, 1, 2, 2, 2, 0);
    push('{0, 1, 4, 5, 8, 9, 12, 13});
    start_run();
    run_loop("delay", 20, 4, 8, 0, 0);

    cfg(0, 4, 2, 0, 1, 0, 2, 2, 0);
    start_run();
    run_loop("iter0", 1, 0, 0, 0, 0);

    cfg(10, 4, 7, 0, 1, 1, 1, 0, 0);
    push('{10, 11, 12, 13});
    start_run();
    run_loop("duty_clamp", 5, 1, 4, 0, 0);

    cfg(1020, 2, 1, 0, 5, 3, 0, 1, 0);
    push('{1020, 2, 8});
    start_run();
    run_loop("wrap_mod", 7, 1, 3, 0, 0);

    cfg(0, 4, 2, 0, 1, 2, 2, 2, 0);
    push('{0, 1, 4, 5, 8, 9, 12, 13});
    start_run();
    run_loop("pause", 20, 1, 8, 6, 3);

    cfg(0, 4, 2, 0, 1, 2, 2, 2, 0);
    push('{0, 1, 4});
    start_run();
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1;
    @(posedge clk); #1;
    rst_i = 0;
    check("midrst_addr", int'(addr_o), 0);
    check("midrst_en", int'(mem_en_o), 0);
    check("midrst_done", int'(done_o), 1);
    check("midrst_q", q.size(), 0);
    q.delete();

    cfg(0, 4, 2, 0, 1, 2, 2, 2, 0);
    push('{0, 1});
    start_run();
    cfg(100, 1, 1, 0, 3, 2, 3, 0, -5);
    push('{100, 103, 101, 104, 102, 105});
    start_run();
    run_loop("restart", 7, 1, 6, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
